// File: rtl/craps_round_sequencer.sv
// One craps round: roll-button edge detect, dice req/ack handshake, come-out/point
// resolution, timed WIN/LOSE display and saturating win/loss tallies.
module craps_round_sequencer #(
    parameter int CNT_W        = 8,
    parameter int HOLD_CYCLES  = 4,
    parameter int DICE_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             roll,
    output logic             dice_req,
    input  logic             dice_ack,
    input  logic [2:0]       die_a,
    input  logic [2:0]       die_b,
    output logic [3:0]       sum,
    output logic [3:0]       point,
    output logic [1:0]       op,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] win_count,
    output logic [CNT_W-1:0] loss_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_POINT = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [1:0] OP_INIT   = 2'b00;
    localparam logic [1:0] OP_REROLL = 2'b01;
    localparam logic [1:0] OP_WIN    = 2'b10;
    localparam logic [1:0] OP_LOSE   = 2'b11;

    localparam int TMR_W = $clog2(DICE_TIMEOUT + 1);
    localparam int HLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DICE_TIMEOUT - 1);
    localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    function automatic logic die_legal(input logic [2:0] d);
        return (d != 3'd0) && (d != 3'd7);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    state_t             state_q, state_d;
    logic               phase_q, phase_d;     // 0 = come-out, 1 = point
    logic               roll_q;
    logic               dice_req_q, dice_req_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [HLD_W-1:0]   hold_q, hold_d;
    logic [3:0]         sum_q, sum_d;
    logic [3:0]         point_q, point_d;
    logic [1:0]         op_q, op_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   win_q, win_d;
    logic [CNT_W-1:0]   loss_q, loss_d;
    logic               rise_s;
    logic [3:0]         roll_sum_s;
    state_t             back_state_s;

    assign rise_s       = roll & ~roll_q;
    assign roll_sum_s   = {1'b0, die_a} + {1'b0, die_b};
    assign back_state_s = phase_q ? ST_POINT : ST_IDLE;

    // Next-state, round resolution and output register inputs
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        dice_req_d = dice_req_q;
        timer_d    = timer_q;
        hold_d     = hold_q;
        sum_d      = sum_q;
        point_d    = point_q;
        op_d       = op_q;
        err_d      = 1'b0;
        win_d      = win_q;
        loss_d     = loss_q;
        case (state_q)
            ST_IDLE, ST_POINT: begin
                if (rise_s) begin
                    state_d    = ST_REQ;
                    phase_d    = (state_q == ST_POINT);
                    dice_req_d = 1'b1;
                    timer_d    = '0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_REQ: begin
                // ack is checked first so it wins over a same-cycle timeout
                if (dice_ack) begin
                    dice_req_d = 1'b0;
                    if (!die_legal(die_a) || !die_legal(die_b)) begin
                        err_d   = 1'b1;
                        state_d = back_state_s;
                    end else begin
                        sum_d = roll_sum_s;
                        if ((!phase_q && (roll_sum_s == 4'd7 || roll_sum_s == 4'd11)) ||
                            (phase_q && (roll_sum_s == point_q))) begin
                            op_d    = OP_WIN;
                            state_d = ST_HOLD;
                            hold_d  = '0;
                            win_d   = sat_inc(win_q);
                        end else if ((!phase_q && (roll_sum_s == 4'd2 || roll_sum_s == 4'd3 ||
                                                   roll_sum_s == 4'd12)) ||
                                     (phase_q && (roll_sum_s == 4'd7))) begin
                            op_d    = OP_LOSE;
                            state_d = ST_HOLD;
                            hold_d  = '0;
                            loss_d  = sat_inc(loss_q);
                        end else begin
                            op_d    = OP_REROLL;
                            state_d = ST_POINT;
                            point_d = phase_q ? point_q : roll_sum_s;
                        end
                    end
                end else if (timer_q == TMR_LAST) begin
                    dice_req_d = 1'b0;
                    err_d      = 1'b1;
                    state_d    = back_state_s;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_HOLD: begin
                if (hold_q == HLD_LAST) begin
                    state_d = ST_IDLE;
                    op_d    = OP_INIT;
                    point_d = 4'd0;
                end else begin
                    hold_d = hold_q + HLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_REQ) || (state_d == ST_HOLD);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            phase_q    <= 1'b0;
            roll_q     <= 1'b0;
            dice_req_q <= 1'b0;
            timer_q    <= '0;
            hold_q     <= '0;
            sum_q      <= 4'd0;
            point_q    <= 4'd0;
            op_q       <= OP_INIT;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            win_q      <= '0;
            loss_q     <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            roll_q     <= roll;
            dice_req_q <= dice_req_d;
            timer_q    <= timer_d;
            hold_q     <= hold_d;
            sum_q      <= sum_d;
            point_q    <= point_d;
            op_q       <= op_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            win_q      <= win_d;
            loss_q     <= loss_d;
        end
    end

    assign dice_req   = dice_req_q;
    assign sum        = sum_q;
    assign point      = point_q;
    assign op         = op_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign win_count  = win_q;
    assign loss_count = loss_q;

endmodule

// File: tb/tb_craps_round_sequencer.sv
// Directed bench for craps_round_sequencer: inputs change at negedge, outputs
// are sampled at negedge, expected values are hand-computed per scenario.
module tb_craps_round_sequencer;

    logic       clk = 1'b0;
    logic       reset, roll, dice_ack;
    logic [2:0] die_a, die_b;
    logic       dice_req, busy, err;
    logic [3:0] sum, point;
    logic [1:0] op;
    logic [7:0] win_count, loss_count;

    int checks   = 0;
    int failures = 0;

    craps_round_sequencer #(.CNT_W(8), .HOLD_CYCLES(4), .DICE_TIMEOUT(255)) dut (
        .clk(clk), .reset(reset), .roll(roll), .dice_req(dice_req), .dice_ack(dice_ack),
        .die_a(die_a), .die_b(die_b), .sum(sum), .point(point), .op(op), .busy(busy),
        .err(err), .win_count(win_count), .loss_count(loss_count)
    );

    always #5 clk = ~clk;

    // One-cycle roll pulse; returns at the negedge after the rise edge
    task automatic do_roll();
        @(negedge clk); roll = 1'b1;
        @(negedge clk); roll = 1'b0;
    endtask

    // Present one dice pair with ack for one cycle; returns after the ack edge
    task automatic give_dice(input logic [2:0] a, input logic [2:0] b);
        int n = 0;
        while (dice_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (dice_req !== 1'b1) begin failures++; $display("FAIL dice_req_wait actual=%b required=1", dice_req); end
        die_a = a; die_b = b; dice_ack = 1'b1;
        @(negedge clk); dice_ack = 1'b0;
    endtask

    task automatic wait_hold();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; roll = 1'b0; dice_ack = 1'b0; die_a = 3'd0; die_b = 3'd0;
        repeat (2) @(negedge clk);
        checks++; if (dice_req !== 1'b0) begin failures++; $display("FAIL rst_req actual=%b required=0", dice_req); end
        checks++; if (sum !== 4'd0 || point !== 4'd0) begin failures++; $display("FAIL rst_sum_point actual=%0d/%0d required=0/0", sum, point); end
        checks++; if (op !== 2'b00 || busy !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL rst_op_busy_err actual=%b/%b/%b required=00/0/0", op, busy, err); end
        checks++; if (win_count !== 8'd0 || loss_count !== 8'd0) begin failures++; $display("FAIL rst_counts actual=%0d/%0d required=0/0", win_count, loss_count); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_come_out_win();
        do_roll();
        checks++; if (dice_req !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL win_req actual=%b/%b required=1/1", dice_req, busy); end
        give_dice(3'd3, 3'd4);
        checks++; if (sum !== 4'd7 || op !== 2'b10) begin failures++; $display("FAIL win_result actual=%0d/%b required=7/10", sum, op); end
        checks++; if (win_count !== 8'd1 || dice_req !== 1'b0) begin failures++; $display("FAIL win_count actual=%0d/%b required=1/0", win_count, dice_req); end
        roll = 1'b1;
        @(negedge clk); roll = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (op !== 2'b10 || busy !== 1'b1) begin failures++; $display("FAIL hold_op actual=%b/%b required=10/1", op, busy); end
        @(negedge clk);
        checks++; if (op !== 2'b00 || busy !== 1'b0 || sum !== 4'd7) begin failures++; $display("FAIL hold_end actual=%b/%b/%0d required=00/0/7", op, busy, sum); end
        @(negedge clk);
        checks++; if (dice_req !== 1'b0) begin failures++; $display("FAIL hold_rise_ignored actual=%b required=0", dice_req); end
    endtask

    task automatic test_point_win();
        do_roll(); give_dice(3'd2, 3'd2);
        checks++; if (op !== 2'b01 || point !== 4'd4 || sum !== 4'd4 || busy !== 1'b0) begin failures++; $display("FAIL point_set actual=%b/%0d/%0d/%b required=01/4/4/0", op, point, sum, busy); end
        do_roll();
        checks++; if (busy !== 1'b1 || op !== 2'b01) begin failures++; $display("FAIL point_req actual=%b/%b required=1/01", busy, op); end
        give_dice(3'd5, 3'd1);
        checks++; if (op !== 2'b01 || sum !== 4'd6 || point !== 4'd4) begin failures++; $display("FAIL point_reroll actual=%b/%0d/%0d required=01/6/4", op, sum, point); end
        die_a = 3'd6; die_b = 3'd6; dice_ack = 1'b1;
        @(negedge clk); dice_ack = 1'b0;
        checks++; if (sum !== 4'd6 || loss_count !== 8'd0) begin failures++; $display("FAIL stray_ack actual=%0d/%0d required=6/0", sum, loss_count); end
        do_roll(); give_dice(3'd3, 3'd1);
        checks++; if (op !== 2'b10 || win_count !== 8'd2 || point !== 4'd4) begin failures++; $display("FAIL point_win actual=%b/%0d/%0d required=10/2/4", op, win_count, point); end
        wait_hold();
        checks++; if (op !== 2'b00 || point !== 4'd0 || sum !== 4'd4) begin failures++; $display("FAIL point_clear actual=%b/%0d/%0d required=00/0/4", op, point, sum); end
    endtask

    task automatic test_lose();
        do_roll(); give_dice(3'd4, 3'd2);
        checks++; if (point !== 4'd6) begin failures++; $display("FAIL lose_point actual=%0d required=6", point); end
        do_roll(); give_dice(3'd3, 3'd4);
        checks++; if (op !== 2'b11 || loss_count !== 8'd1 || sum !== 4'd7) begin failures++; $display("FAIL seven_out actual=%b/%0d/%0d required=11/1/7", op, loss_count, sum); end
        wait_hold();
        checks++; if (op !== 2'b00 || point !== 4'd0) begin failures++; $display("FAIL lose_clear actual=%b/%0d required=00/0", op, point); end
        do_roll(); give_dice(3'd6, 3'd6);
        checks++; if (op !== 2'b11 || loss_count !== 8'd2 || sum !== 4'd12) begin failures++; $display("FAIL craps12 actual=%b/%0d/%0d required=11/2/12", op, loss_count, sum); end
        wait_hold();
        do_roll(); give_dice(3'd5, 3'd6);
        checks++; if (op !== 2'b10 || win_count !== 8'd3 || sum !== 4'd11) begin failures++; $display("FAIL natural11 actual=%b/%0d/%0d required=10/3/11", op, win_count, sum); end
        wait_hold();
    endtask

    task automatic test_errors();
        int n = 0;
        do_roll();
        while (dice_req === 1'b1 && n < 300) begin n++; @(negedge clk); end
        checks++; if (n != 255) begin failures++; $display("FAIL timeout_len actual=%0d required=255", n); end
        checks++; if (err !== 1'b1 || op !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL timeout_err actual=%b/%b/%b required=1/00/0", err, op, busy); end
        @(negedge clk);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_pulse actual=%b required=0", err); end
        do_roll(); give_dice(3'd7, 3'd3);
        checks++; if (err !== 1'b1 || sum !== 4'd11 || op !== 2'b00 || dice_req !== 1'b0) begin failures++; $display("FAIL illegal_die actual=%b/%0d/%b/%b required=1/11/00/0", err, sum, op, dice_req); end
        checks++; if (win_count !== 8'd3 || loss_count !== 8'd2) begin failures++; $display("FAIL illegal_counts actual=%0d/%0d required=3/2", win_count, loss_count); end
        do_roll(); give_dice(3'd4, 3'd1);
        do_roll(); give_dice(3'd0, 3'd2);
        checks++; if (err !== 1'b1 || op !== 2'b01 || point !== 4'd5 || sum !== 4'd5) begin failures++; $display("FAIL illegal_point actual=%b/%b/%0d/%0d required=1/01/5/5", err, op, point, sum); end
        do_roll(); give_dice(3'd3, 3'd2);
        checks++; if (op !== 2'b10 || win_count !== 8'd4) begin failures++; $display("FAIL after_illegal_win actual=%b/%0d required=10/4", op, win_count); end
        wait_hold();
        do_roll();
        repeat (254) @(negedge clk);
        die_a = 3'd2; die_b = 3'd5; dice_ack = 1'b1;
        @(negedge clk); dice_ack = 1'b0;
        checks++; if (err !== 1'b0 || op !== 2'b10 || win_count !== 8'd5 || sum !== 4'd7) begin failures++; $display("FAIL ack_at_timeout actual=%b/%b/%0d/%0d required=0/10/5/7", err, op, win_count, sum); end
        wait_hold();
    endtask

    task automatic test_reset_and_saturation();
        do_roll(); give_dice(3'd4, 3'd5);
        do_roll();
        checks++; if (dice_req !== 1'b1 || point !== 4'd9) begin failures++; $display("FAIL mid_req_setup actual=%b/%0d required=1/9", dice_req, point); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (dice_req !== 1'b0 || point !== 4'd0 || op !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL mid_req_reset actual=%b/%0d/%b/%b required=0/0/00/0", dice_req, point, op, busy); end
        checks++; if (win_count !== 8'd0 || sum !== 4'd0) begin failures++; $display("FAIL mid_req_clear actual=%0d/%0d required=0/0", win_count, sum); end
        reset = 1'b0;
        for (int i = 0; i < 257; i++) begin
            do_roll(); give_dice(3'd3, 3'd4);
            if (i == 254) begin
                checks++; if (win_count !== 8'd255) begin failures++; $display("FAIL win_reach_max actual=%0d required=255", win_count); end
            end
            wait_hold();
        end
        checks++; if (win_count !== 8'hFF || loss_count !== 8'd0) begin failures++; $display("FAIL win_saturate actual=%0d/%0d required=255/0", win_count, loss_count); end
    endtask

    initial begin
        test_reset();
        test_come_out_win();
        test_point_win();
        test_lose();
        test_errors();
        test_reset_and_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
